sw_result_collector: RTL and testbench
======================================

// Module: sw_result_collector
// PURPOSE
//  Downstream of the SmithWaterman core. Consumes the per-target score stream
//  (valid/result/change_q/match_idx/max_result) and packs one summary record per
//  finished query into a small FIFO. Records drain over a valid/ready port.
//  Flags the end of the run and FIFO overflow; optionally cross-checks the
//  core's reported best match.
// PARAMETERS
//  CALC_BIT       10  score width; matches core result_o/max_result_o
//  MAX_T_NUM_BIT  8   target index width; matches core match_idx_o
//  Q_IDX_BIT      8   query counter width; wraps modulo 2^Q_IDX_BIT
//  FIFO_DEPTH     4   record FIFO entries; power of 2, >=2
//  RW = Q_IDX_BIT + (MAX_T_NUM_BIT+1) + MAX_T_NUM_BIT + CALC_BIT
// PORTS
//  clk           in   1              clock; all logic on posedge
//  rst           in   1              synchronous, active-high reset
//  start_i       in   1              same pulse that starts the core
//  busy_i        in   1              core busy_o
//  valid_i       in   1              core valid_o, one pulse per target score
//  result_i      in   CALC_BIT       core result_o
//  change_q_i    in   1              core change_q_o; qualified by valid_i
//  match_idx_i   in   MAX_T_NUM_BIT  core match_idx_o; qualified by valid_i&change_q_i
//  max_result_i  in   CALC_BIT       core max_result_o; same qualification
//  out_valid_o   out  1              FIFO head holds a record
//  out_ready_i   in   1              consumer accepts head when out_valid_o=1
//  out_data_o    out  RW             {q_idx, t_count, match_idx, max_result}
//  done_o        out  1              run finished (FSM in DONE)
//  overflow_o    out  1              sticky: a record was dropped
//  err_o         out  1              sticky: self-check mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; q_idx=0; t_count=0; all outputs 0. Reset in any
//   state discards FIFO contents and clears sticky flags.
//  FSM IDLE -> RUN on start_i. Entry clears q_idx, t_count, overflow_o, err_o.
//   FIFO is not flushed.
//  RUN -> DONE on the first cycle busy_i=0 that follows at least one cycle with
//   busy_i=1 in RUN. start_i in RUN is ignored.
//  DONE: done_o=1. DONE -> RUN on start_i with the same clears. Draining is
//   allowed in every state.
//  valid_i=0: counters hold. valid_i and change_q_i outside RUN are ignored.
//  valid_i=1 & change_q_i=0: t_count+1, saturating at 2^MAX_T_NUM_BIT.
//  valid_i=1 & change_q_i=1: push record {q_idx, t_count+1, match_idx_i,
//   max_result_i}; then q_idx+1 (wraps) and t_count=0.
//  Push latency: out_valid_o rises the cycle after the change_q valid if the FIFO
//   was empty. No combinational path from inputs to outputs.
//  Pop: out_valid_o & out_ready_i. out_data_o is stable while out_valid_o=1 and
//   out_ready_i=0.
//  Full + push without pop: record dropped; overflow_o=1; q_idx still increments.
//  Full + push with pop in the same cycle: both happen; no overflow.
//  Empty + pop request: no effect. Pointers are log2(FIFO_DEPTH)+1 bits and wrap.
// CONFIGURATION
//  SW_RESULT_CHECK_EN defined:
//   - Track running max score and its target index per query. Update on strictly
//     greater scores only, so the first index wins ties.
//   - Reset the tracker at each record push.
//   - When the push is requested (accepted or dropped), compare the tracker with
//     max_result_i/match_idx_i, including the closing sample. On mismatch, err_o=1
//     (sticky).
//  SW_RESULT_CHECK_EN undefined: no tracker logic; err_o tied to 0.
// TESTING
//  1 Reset, start, 3 valids scores 5,9,9, last with change_q, idx=1, max=9,
//    ready=1 -> one record {0,3,1,9}; err_o=0.
//  2 Same stream but core reports idx=2 -> err_o=1 with CHECK_EN defined; 0 without.
//  3 ready=0, 5 queries, DEPTH=4 -> 4 records held, overflow_o=1. Then drain:
//    q_idx 0..3 in order, and no record with q_idx=4.
//  4 FIFO full, push and pop in the same cycle -> count stays 4, overflow_o=0,
//    head advances by one.
//  5 busy 1->0 -> done_o=1 next cycle. New start_i -> done_o=0, q_idx restarts at 0.
//  6 rst asserted mid-run with 2 records queued -> next cycle out_valid_o=0,
//    IDLE, flags cleared.

Source files
------------

// File: rtl/sw_result_collector.sv
// Packs one summary record per finished SmithWaterman query into a small FIFO drained over valid/ready.
// Define SW_RESULT_CHECK_EN to cross-check the core's reported best match (drives err_o).
module sw_result_collector #(
    parameter int CALC_BIT      = 10,
    parameter int MAX_T_NUM_BIT = 8,
    parameter int Q_IDX_BIT     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int RW            = Q_IDX_BIT + (MAX_T_NUM_BIT + 1) + MAX_T_NUM_BIT + CALC_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     busy_i,
    input  logic                     valid_i,
    input  logic [CALC_BIT-1:0]      result_i,
    input  logic                     change_q_i,
    input  logic [MAX_T_NUM_BIT-1:0] match_idx_i,
    input  logic [CALC_BIT-1:0]      max_result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RW-1:0]            out_data_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     err_o,
    output logic [1:0]               dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = MAX_T_NUM_BIT + 1;
    localparam logic [TW-1:0]        T_SAT   = {1'b1, {MAX_T_NUM_BIT{1'b0}}};
    localparam logic [TW-1:0]        T_ONE   = 1;
    localparam logic [Q_IDX_BIT-1:0] Q_ONE   = 1;
    localparam logic [AW:0]          P_ONE   = 1;
    localparam logic [AW:0]          DEPTH_P = FIFO_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   seen_busy_q, seen_busy_d;
    logic [Q_IDX_BIT-1:0]   q_idx_q, q_idx_d;
    logic [TW-1:0]          t_count_q, t_count_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]          mem_q [FIFO_DEPTH];
    logic [RW-1:0]          mem_d [FIFO_DEPTH];
    logic                   overflow_q, overflow_d;

    logic                   sample;
    logic                   push_req;
    logic                   push_ok;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   enter_run;
    logic [TW-1:0]          t_inc;

    assign sample    = (state_q == S_RUN) && valid_i;
    assign push_req  = sample && change_q_i;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign pop       = !empty && out_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_req && (!full || pop);
    assign enter_run = start_i && (state_q != S_RUN);
    assign t_inc     = (t_count_q == T_SAT) ? T_SAT : (t_count_q + T_ONE);

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        q_idx_d     = q_idx_q;
        t_count_d   = t_count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN: begin
                if (busy_i) seen_busy_d = 1'b1;
                else if (seen_busy_q) state_d = S_DONE;
            end
            S_DONE: if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (sample) begin
            if (change_q_i) begin
                q_idx_d   = q_idx_q + Q_ONE;
                t_count_d = '0;
            end else begin
                t_count_d = t_inc;
            end
        end

        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = {q_idx_q, t_inc, match_idx_i, max_result_i};
            wr_ptr_d = wr_ptr_q + P_ONE;
        end
        if (push_req && !push_ok) overflow_d = 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + P_ONE;

        if (enter_run) begin
            q_idx_d     = '0;
            t_count_d   = '0;
            overflow_d  = 1'b0;
            seen_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seen_busy_q <= 1'b0;
            q_idx_q     <= '0;
            t_count_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            q_idx_q     <= q_idx_d;
            t_count_q   <= t_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SW_RESULT_CHECK_EN
    logic [CALC_BIT-1:0]      trk_max_q, trk_max_d;
    logic [MAX_T_NUM_BIT-1:0] trk_idx_q, trk_idx_d;
    logic                     trk_vld_q, trk_vld_d;
    logic                     err_q, err_d;
    logic [CALC_BIT-1:0]      cand_max;
    logic [MAX_T_NUM_BIT-1:0] cand_idx;

    // Candidate includes the current sample so the closing score is part of the check.
    always_comb begin
        cand_max  = trk_max_q;
        cand_idx  = trk_idx_q;
        trk_max_d = trk_max_q;
        trk_idx_d = trk_idx_q;
        trk_vld_d = trk_vld_q;
        err_d     = err_q;
        if (!trk_vld_q || (result_i > trk_max_q)) begin
            cand_max = result_i;
            cand_idx = t_count_q[MAX_T_NUM_BIT-1:0];
        end
        if (sample) begin
            if (change_q_i) begin
                trk_vld_d = 1'b0;
                if ((cand_max != max_result_i) || (cand_idx != match_idx_i)) err_d = 1'b1;
            end else begin
                trk_max_d = cand_max;
                trk_idx_d = cand_idx;
                trk_vld_d = 1'b1;
            end
        end
        if (enter_run) begin
            trk_vld_d = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_max_q <= '0;
            trk_idx_q <= '0;
            trk_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            trk_max_q <= trk_max_d;
            trk_idx_q <= trk_idx_d;
            trk_vld_q <= trk_vld_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign out_valid_o = !empty;
    assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign done_o      = (state_q == S_DONE);
    assign overflow_o  = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sw_result_collector.sv
// Scoreboard bench for sw_result_collector: records predicted at push time, compared when popped.
module tb_sw_result_collector;
  localparam int CALC_BIT      = 10;
  localparam int MAX_T_NUM_BIT = 8;
  localparam int Q_IDX_BIT     = 8;
  localparam int FIFO_DEPTH    = 4;
  localparam int TW            = MAX_T_NUM_BIT + 1;
  localparam int RW            = Q_IDX_BIT + TW + MAX_T_NUM_BIT + CALC_BIT;
  localparam int T_SAT         = 1 << MAX_T_NUM_BIT;

  logic                     clk;
  logic                     rst;
  logic                     start_i;
  logic                     busy_i;
  logic                     valid_i;
  logic [CALC_BIT-1:0]      result_i;
  logic                     change_q_i;
  logic [MAX_T_NUM_BIT-1:0] match_idx_i;
  logic [CALC_BIT-1:0]      max_result_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [RW-1:0]            out_data_o;
  logic                     done_o;
  logic                     overflow_o;
  logic                     err_o;
  logic [1:0]               dbg_state_o;

  sw_result_collector #(
    .CALC_BIT(CALC_BIT), .MAX_T_NUM_BIT(MAX_T_NUM_BIT),
    .Q_IDX_BIT(Q_IDX_BIT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_i(busy_i),
    .valid_i(valid_i), .result_i(result_i), .change_q_i(change_q_i),
    .match_idx_i(match_idx_i), .max_result_i(max_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .done_o(done_o), .overflow_o(overflow_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [RW-1:0]            exp_q[$];
  int                       n_checks = 0;
  int                       n_fail   = 0;
  int                       n_pops   = 0;
  int                       m_state  = 0;   // 0 idle, 1 run, 2 done
  bit                       m_seen;
  logic [Q_IDX_BIT-1:0]     m_q;
  int                       m_t;
  bit                       m_ovf;
  bit                       m_err;
  int                       sc[$];
  logic [CALC_BIT-1:0]      true_max;
  logic [MAX_T_NUM_BIT-1:0] true_idx;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_seen = 0; m_q = '0; m_t = 0; m_ovf = 0; m_err = 0;
    exp_q.delete();
  endtask

  // One clock: check outputs, predict the effect of the current inputs, advance.
  task automatic cycle();
    logic [RW-1:0] rec;
    logic [TW-1:0] tn_v;
    int            tn;
    check_eq("out_valid", out_valid_o, exp_q.size() > 0);
    check_eq("done", done_o, m_state == 2);
    check_eq("overflow", overflow_o, m_ovf);
    check_eq("err", err_o, m_err);
    if (out_ready_i && exp_q.size() > 0) begin
      check_eq("out_data", out_data_o, exp_q.pop_front());
      n_pops++;
    end
    if (m_state == 1 && valid_i) begin
      tn = (m_t >= T_SAT) ? T_SAT : m_t + 1;
      if (change_q_i) begin
        tn_v = tn[TW-1:0];
        rec  = {m_q, tn_v, match_idx_i, max_result_i};
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(rec);
        else m_ovf = 1;
`ifdef SW_RESULT_CHECK_EN
        if (match_idx_i != true_idx || max_result_i != true_max) m_err = 1;
`endif
        m_q = m_q + 1'b1;
        m_t = 0;
      end else begin
        m_t = tn;
      end
    end
    case (m_state)
      0, 2: if (start_i) begin
        m_state = 1; m_seen = 0; m_q = '0; m_t = 0; m_ovf = 0; m_err = 0;
      end
      default: begin
        if (busy_i) m_seen = 1;
        else if (m_seen) m_state = 2;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic gen_scores(input int n);
    sc.delete();
    for (int i = 0; i < n; i++) sc.push_back(int'($urandom_range(0, 1023)));
  endtask

  task automatic send_query(input int n, input bit bad, input bit pop_last);
    logic [MAX_T_NUM_BIT-1:0] iv;
    bit                       saved_ready;
    true_max = sc[0][CALC_BIT-1:0];
    true_idx = '0;
    for (int i = 1; i < n; i++) begin
      if (sc[i][CALC_BIT-1:0] > true_max) begin
        true_max = sc[i][CALC_BIT-1:0];
        iv = i[MAX_T_NUM_BIT-1:0];
        true_idx = iv;
      end
    end
    saved_ready = out_ready_i;
    for (int i = 0; i < n; i++) begin
      valid_i    = 1'b1;
      result_i   = sc[i][CALC_BIT-1:0];
      change_q_i = (i == n - 1);
      if (i == n - 1) begin
        match_idx_i  = bad ? true_idx + 1'b1 : true_idx;
        max_result_i = true_max;
        if (pop_last) out_ready_i = 1'b1;
      end else begin
        match_idx_i  = MAX_T_NUM_BIT'($urandom_range(0, 255));
        max_result_i = CALC_BIT'($urandom_range(0, 1023));
      end
      cycle();
      valid_i     = 1'b0;
      change_q_i  = 1'b0;
      out_ready_i = saved_ready;
      if ($urandom_range(0, 1) == 1) cycle();
    end
  endtask

  task automatic start_run();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    busy_i  = 1'b1;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; start_i = 0; busy_i = 0; valid_i = 0; result_i = '0;
    change_q_i = 0; match_idx_i = '0; max_result_i = '0; out_ready_i = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    check_eq("rst_state", dbg_state_o, 2'd0);
    check_eq("rst_data", out_data_o, '0);
    cycle();

    // basic record {0,3,1,9}, no error
    out_ready_i = 1'b1;
    start_run();
    sc = '{5, 9, 9};
    send_query(3, 1'b0, 1'b0);
    cycle();
    check_eq("basic_pops", n_pops, 1);
    check_eq("basic_err", err_o, 1'b0);

    // wrong index reported by the core
    sc = '{5, 9, 9};
    send_query(3, 1'b1, 1'b0);
    cycle();
`ifdef SW_RESULT_CHECK_EN
    check_eq("bad_idx_err", err_o, 1'b1);
`else
    check_eq("bad_idx_err", err_o, 1'b0);
`endif

    // end of run
    busy_i = 1'b0;
    cycle();
    check_eq("done_set", done_o, 1'b1);
    cycle();

    // overflow: 5 queries, nothing drained
    out_ready_i = 1'b0;
    start_run();
    check_eq("done_clr", done_o, 1'b0);
    for (int k = 0; k < 5; k++) begin
      gen_scores(int'($urandom_range(1, 4)));
      send_query(sc.size(), 1'b0, 1'b0);
    end
    cycle();
    check_eq("ovf_set", overflow_o, 1'b1);
    check_eq("full_head_q", out_data_o[RW-1 -: Q_IDX_BIT], 0);
    out_ready_i = 1'b1;
    n_pops = 0;
    repeat (FIFO_DEPTH + 2) cycle();
    check_eq("drain_pops", n_pops, FIFO_DEPTH);

    // full FIFO with simultaneous push and pop
    busy_i = 1'b0;
    cycle(); cycle();
    out_ready_i = 1'b0;
    start_run();
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      gen_scores(int'($urandom_range(1, 3)));
      send_query(sc.size(), 1'b0, 1'b0);
    end
    gen_scores(2);
    send_query(2, 1'b0, 1'b1);
    cycle();
    check_eq("pp_no_ovf", overflow_o, 1'b0);
    check_eq("pp_head_q", out_data_o[RW-1 -: Q_IDX_BIT], 1);
    out_ready_i = 1'b1;
    n_pops = 0;
    repeat (FIFO_DEPTH + 2) cycle();
    check_eq("pp_pops", n_pops, FIFO_DEPTH);

    // t_count saturation on a long query
    sc.delete();
    for (int i = 0; i < 300; i++) sc.push_back((i == 3) ? 50 : 0);
    send_query(300, 1'b0, 1'b0);
    cycle(); cycle();

    // reset mid-run with records queued
    out_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      gen_scores(2);
      send_query(2, 1'b0, 1'b0);
    end
    cycle();
    check_eq("pre_rst_valid", out_valid_o, 1'b1);
    do_reset();
    check_eq("mid_rst_valid", out_valid_o, 1'b0);
    check_eq("mid_rst_state", dbg_state_o, 2'd0);
    check_eq("mid_rst_ovf", overflow_o, 1'b0);
    check_eq("mid_rst_err", err_o, 1'b0);
    busy_i = 1'b0;
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
